// File: rtl/ula_sequenciador_pkg.sv
// Shared constants for the ALU sequencer: command codes, ALU select codes
// and the controller state encoding.
package ula_sequenciador_pkg;

    localparam logic [4:0] CMD_ADD = 5'd0;
    localparam logic [4:0] CMD_SUB = 5'd1;
    localparam logic [4:0] CMD_MUL = 5'd2;
    localparam logic [4:0] CMD_AND = 5'd3;
    localparam logic [4:0] CMD_OR  = 5'd4;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic cmdIsLegal(input logic [4:0] cmd);
        return cmd <= CMD_OR;
    endfunction

    // Illegal codes map to ADD; their result is masked by the sequencer anyway.
    function automatic logic [2:0] cmdToSel(input logic [4:0] cmd);
        logic [2:0] sel;
        case (cmd)
            CMD_SUB: sel = ALU_SUB;
            CMD_MUL: sel = ALU_MUL;
            CMD_AND: sel = ALU_AND;
            CMD_OR:  sel = ALU_OR;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ula_sequenciador_alu.sv
// The team's 4-bit ALU: purely combinational, 8-bit result plus the carry
// out of a+b regardless of the selected operation.
module ula_sequenciador_alu
    import ula_sequenciador_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [2:0] sel_i,
    output logic [7:0] result_o,
    output logic       carry_o
);

    logic [4:0] sum;

    assign sum     = {1'b0, a_i} + {1'b0, b_i};
    assign carry_o = sum[4];

    always_comb begin
        result_o = 8'h00;
        case (sel_i)
            ALU_ADD: result_o = {3'b000, sum};
            ALU_SUB: result_o = {4'h0, a_i} - {4'h0, b_i};
            ALU_MUL: result_o = {4'h0, a_i} * {4'h0, b_i};
            ALU_AND: result_o = {4'h0, a_i & b_i};
            ALU_OR:  result_o = {4'h0, a_i | b_i};
            default: result_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/ula_sequenciador.sv
// Command/result handshake wrapper around the 4-bit ALU: IDLE latches a
// command, EXEC registers the ALU output, DONE holds it until acknowledged.
module ula_sequenciador
    import ula_sequenciador_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [4:0]       cmd,
    input  logic [3:0]       op_a,
    input  logic [3:0]       op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       result,
    output logic             res_carry,
    output logic             res_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [4:0]       cmd_q;
    logic [3:0]       a_q, b_q;
    logic [7:0]       result_q;
    logic             carry_q, err_q, valid_q;
    logic [CNT_W-1:0] count_q;

    logic             load_cmd, load_res, ack_res;
    logic [7:0]       alu_result;
    logic             alu_carry;
    logic             legal;

    ula_sequenciador_alu u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .sel_i    (cmdToSel(cmd_q)),
        .result_o (alu_result),
        .carry_o  (alu_carry)
    );

    assign legal     = cmdIsLegal(cmd_q);
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        load_cmd = 1'b0;
        load_res = 1'b0;
        ack_res  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    load_cmd = 1'b1;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                load_res = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) begin
                    ack_res = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result registers keep their last value in IDLE; only reset clears them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cmd_q    <= 5'd0;
            a_q      <= 4'h0;
            b_q      <= 4'h0;
            result_q <= 8'h00;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_cmd) begin
                cmd_q <= cmd;
                a_q   <= op_a;
                b_q   <= op_b;
            end
            if (load_res) begin
                result_q <= legal ? alu_result : 8'h00;
                carry_q  <= legal ? alu_carry : 1'b0;
                err_q    <= ~legal;
                valid_q  <= 1'b1;
            end
            if (ack_res) begin
                valid_q <= 1'b0;
                if (!err_q && count_q != CNT_MAX) begin
                    count_q <= count_q + 1'b1;
                end
            end
        end
    end

    assign result    = result_q;
    assign res_carry = carry_q;
    assign res_err   = err_q;
    assign res_valid = valid_q;
    assign op_count  = count_q;

endmodule

// File: tb/tb_ula_sequenciador.sv
// Scoreboard bench for ula_sequenciador: directed scenarios then random
// commands, checked by a negedge monitor against an arithmetic reference.
module tb_ula_sequenciador;

    typedef struct {
        logic [7:0] res;
        logic       carry;
        logic       err;
        int         acceptCycle;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [4:0] cmd = 5'd0;
    logic [3:0] op_a = 4'h0;
    logic [3:0] op_b = 4'h0;
    logic       res_ready = 1'b0;

    logic       cmd_ready, res_valid, res_carry, res_err, busy;
    logic [7:0] result;
    logic [7:0] op_count;

    logic       cmdReady2, resValid2, resCarry2, resErr2, busy2;
    logic [7:0] result2;
    logic [1:0] opCount2;

    exp_t expQ[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   cycleCnt = 0;
    int   legalOps = 0;
    bit   prevValid = 0;
    bit   randomReady = 0;

    ula_sequenciador #(.CNT_W(8)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .op_a(op_a), .op_b(op_b), .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .res_carry(res_carry), .res_err(res_err), .busy(busy),
        .op_count(op_count)
    );

    ula_sequenciador #(.CNT_W(2)) dutSat (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmdReady2),
        .cmd(cmd), .op_a(op_a), .op_b(op_b), .res_valid(resValid2), .res_ready(res_ready),
        .result(result2), .res_carry(resCarry2), .res_err(resErr2), .busy(busy2),
        .op_count(opCount2)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    // Reference ALU written straight from the arithmetic rules of each opcode.
    function automatic exp_t refModel(input logic [4:0] c, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        int ia = a;
        int ib = b;
        int r;
        e.acceptCycle = 0;
        e.err = (c > 5'd4);
        case (c)
            5'd0: r = ia + ib;
            5'd1: r = ia - ib;
            5'd2: r = ia * ib;
            5'd3: r = ia & ib;
            5'd4: r = ia | ib;
            default: r = 0;
        endcase
        e.res   = r[7:0];
        e.carry = e.err ? 1'b0 : (ia + ib >= 16);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drives one command and pushes its expected response once the DUT is ready.
    task automatic applyStimulus(input logic [4:0] c, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        bit accepted = 0;
        @(posedge clock);
        #1;
        cmd_valid = 1'b1;
        cmd = c;
        op_a = a;
        op_b = b;
        for (int k = 0; k < 500; k++) begin
            @(negedge clock);
            if (cmd_ready) begin
                e = refModel(c, a, b);
                e.acceptCycle = cycleCnt + 1;
                expQ.push_back(e);
                accepted = 1;
                break;
            end
        end
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDrain();
        bit drained = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clock);
            if (expQ.size() == 0 && !res_valid) begin
                drained = 1;
                break;
            end
        end
        if (!drained) checkOutput("drain_timeout", 32'd0, 32'd1);
        #2;
    endtask

    // Monitor: pops on each rising res_valid, checks hold-stability and the counters.
    always @(negedge clock) begin
        if (!reset) begin
            prevValid = 0;
        end else begin
            if (res_valid && !prevValid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_result", 32'd1, 32'd0);
                    cur = '{res: result, carry: res_carry, err: res_err, acceptCycle: 0};
                end else begin
                    cur = expQ.pop_front();
                    checkOutput("result", {24'd0, result}, {24'd0, cur.res});
                    checkOutput("res_carry", {31'd0, res_carry}, {31'd0, cur.carry});
                    checkOutput("res_err", {31'd0, res_err}, {31'd0, cur.err});
                    checkOutput("latency", cycleCnt, cur.acceptCycle + 1);
                    checkOutput("sat_result", {24'd0, result2}, {24'd0, cur.res});
                    checkOutput("sat_flags", {29'd0, resValid2, resCarry2, resErr2},
                                {29'd0, 1'b1, cur.carry, cur.err});
                end
            end else if (res_valid) begin
                checkOutput("held_result", {24'd0, result}, {24'd0, cur.res});
                checkOutput("held_err", {31'd0, res_err}, {31'd0, cur.err});
            end
            if (res_valid) begin
                checkOutput("done_handshake", {28'd0, cmd_ready, busy, cmdReady2, busy2}, 32'b0101);
            end
            checkOutput("op_count", {24'd0, op_count}, (legalOps > 255) ? 32'd255 : legalOps);
            checkOutput("op_count_sat", {30'd0, opCount2}, (legalOps > 3) ? 32'd3 : legalOps);
            if (res_valid && res_ready && !cur.err) legalOps++;
            prevValid = res_valid;
        end
    end

    always @(posedge clock) begin
        if (randomReady) begin
            #1;
            res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [7:0] heldResult;

        #12;
        checkOutput("reset_outputs", {20'd0, cmd_ready, res_valid, result, res_carry, res_err, busy},
                    {20'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        checkOutput("reset_count", {24'd0, op_count}, 32'd0);
        @(posedge clock);
        #3;
        reset = 1'b1;
        res_ready = 1'b1;

        applyStimulus(5'd0, 4'd15, 4'd15);
        waitDrain();
        checkOutput("add_count", {24'd0, op_count}, 32'd1);
        applyStimulus(5'd1, 4'd3, 4'd5);
        applyStimulus(5'd2, 4'd15, 4'd15);
        applyStimulus(5'd7, 4'd2, 4'd2);
        waitDrain();
        checkOutput("illegal_count", {24'd0, op_count}, 32'd3);

        // Backpressure: result held for five cycles while a stray command is offered.
        res_ready = 1'b0;
        applyStimulus(5'd2, 4'd4, 4'd5);
        @(posedge clock);
        #1;
        heldResult = result;
        cmd_valid = 1'b1;
        cmd = 5'd1;
        op_a = 4'd1;
        op_b = 4'd1;
        repeat (5) begin
            @(negedge clock);
            checkOutput("bp_stable", {23'd0, res_valid, result}, {23'd0, 1'b1, heldResult});
            checkOutput("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        cmd_valid = 1'b0;
        @(posedge clock);
        #1;
        res_ready = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("bp_idle", {30'd0, busy, res_valid}, 32'd0);
        waitDrain();

        // Reset while the command sits in EXEC: it must vanish without a result.
        @(posedge clock);
        #1;
        cmd_valid = 1'b1;
        cmd = 5'd0;
        op_a = 4'd9;
        op_b = 4'd9;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        checkOutput("exec_busy", {31'd0, busy}, 32'd1);
        #1;
        reset = 1'b0;
        legalOps = 0;
        #1;
        checkOutput("rst_outputs", {20'd0, cmd_ready, res_valid, result, res_carry, res_err, busy},
                    {20'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        checkOutput("rst_count", {24'd0, op_count}, 32'd0);
        @(posedge clock);
        #3;
        reset = 1'b1;
        repeat (6) @(negedge clock);
        checkOutput("rst_no_result", {31'd0, res_valid}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(5'($urandom_range(0, 4)), 4'($urandom), 4'($urandom));
        end
        waitDrain();
        checkOutput("sat_count", {30'd0, opCount2}, 32'd3);
        checkOutput("five_count", {24'd0, op_count}, 32'd5);

        randomReady = 1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(5'($urandom_range(5, 31)), 4'($urandom), 4'($urandom));
            end else begin
                applyStimulus(5'($urandom_range(0, 4)), 4'($urandom), 4'($urandom));
            end
            repeat ($urandom_range(0, 3)) @(posedge clock);
        end
        waitDrain();
        randomReady = 0;
        checkOutput("queue_empty", expQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
